ysyx_25040101_wbu: RTL and testbench

Writeback unit, the write-side driver of the integer register file. It arbitrates completed results from the ALU and the LSU and registers one result per cycle onto the regfile write port (rd_data/rd_addr/rd_wen). It also keeps a per-register pending-write scoreboard that idecode queries to stall on RAW hazards before reading rs1/rs2.

---
 rtl/ysyx_25040101_wbu_if.sv | 48 ++++
 rtl/ysyx_25040101_wbu.sv | 103 ++++++++++
 tb/tb_ysyx_25040101_wbu.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25040101_wbu_if.sv
// Writeback unit bus bundle: issue scoreboard port, ALU/LSU result handshakes,
// regfile write port and idecode source-hazard query.
interface ysyx_25040101_wbu_if;
  logic        iss_valid_i;
  logic        iss_wen_i;
  logic [4:0]  iss_rd_addr_i;
  logic        iss_ready_o;

  logic        alu_valid_i;
  logic        alu_ready_o;
  logic        alu_wen_i;
  logic [4:0]  alu_rd_addr_i;
  logic [31:0] alu_rd_data_i;

  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic        lsu_wen_i;
  logic [4:0]  lsu_rd_addr_i;
  logic [31:0] lsu_rd_data_i;

  logic        rd_wen_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;

  logic [4:0]  rs1_addr_i;
  logic [4:0]  rs2_addr_i;
  logic        busy_o;

  // Environment side: idecode, ALU, LSU and regfile.
  modport master (
    output iss_valid_i, iss_wen_i, iss_rd_addr_i,
    output alu_valid_i, alu_wen_i, alu_rd_addr_i, alu_rd_data_i,
    output lsu_valid_i, lsu_wen_i, lsu_rd_addr_i, lsu_rd_data_i,
    output rs1_addr_i, rs2_addr_i,
    input  iss_ready_o, alu_ready_o, lsu_ready_o,
    input  rd_wen_o, rd_addr_o, rd_data_o, busy_o
  );

  // Writeback unit side.
  modport slave (
    input  iss_valid_i, iss_wen_i, iss_rd_addr_i,
    input  alu_valid_i, alu_wen_i, alu_rd_addr_i, alu_rd_data_i,
    input  lsu_valid_i, lsu_wen_i, lsu_rd_addr_i, lsu_rd_data_i,
    input  rs1_addr_i, rs2_addr_i,
    output iss_ready_o, alu_ready_o, lsu_ready_o,
    output rd_wen_o, rd_addr_o, rd_data_o, busy_o
  );
endinterface

// File: rtl/ysyx_25040101_wbu.sv
// Writeback unit: ALU/LSU result arbitration with ALU anti-starvation, a
// registered regfile write port, and a per-register pending-write scoreboard.
module ysyx_25040101_wbu #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned PEND_W     = 2
) (
  input logic                    clk,
  input logic                    rst,
  ysyx_25040101_wbu_if.slave     bus
);

  localparam logic [3:0]        StarveMax = 4'(STARVE_MAX);
  localparam logic [PEND_W-1:0] PendMax   = '1;
  localparam logic [PEND_W-1:0] PendOne   = PEND_W'(1);

  logic [3:0]        starve_q, starve_d;
  logic              rd_wen_q, rd_wen_d;
  logic [4:0]        rd_addr_q, rd_addr_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic [PEND_W-1:0] cnt_q [32];
  logic [PEND_W-1:0] cnt_d [32];

  logic force_alu, lsu_win, alu_win, iss_fire;

  // Arbitration: LSU normally wins; a starved ALU is forced through.
  always_comb begin
    force_alu = (starve_q == StarveMax);
    lsu_win   = bus.lsu_valid_i && !(force_alu && bus.alu_valid_i);
    alu_win   = bus.alu_valid_i && !lsu_win;
  end

  assign bus.lsu_ready_o = lsu_win;
  assign bus.alu_ready_o = alu_win;
  assign bus.rd_wen_o    = rd_wen_q;
  assign bus.rd_addr_o   = rd_addr_q;
  assign bus.rd_data_o   = rd_data_q;

  // Issue stalls only on a saturated counter; a same-cycle writeback does not help.
  assign bus.iss_ready_o = !(bus.iss_wen_i && (bus.iss_rd_addr_i != 5'd0) &&
                             (cnt_q[bus.iss_rd_addr_i] == PendMax));
  assign iss_fire = bus.iss_valid_i && bus.iss_ready_o && bus.iss_wen_i &&
                    (bus.iss_rd_addr_i != 5'd0);

  // RAW hazard: x0 never has a pending write.
  assign bus.busy_o = ((bus.rs1_addr_i != 5'd0) && (cnt_q[bus.rs1_addr_i] != '0)) ||
                      ((bus.rs2_addr_i != 5'd0) && (cnt_q[bus.rs2_addr_i] != '0));

  // Next-state for starvation counter and output register.
  always_comb begin
    starve_d  = '0;
    rd_wen_d  = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    if (bus.alu_valid_i && !alu_win) begin
      starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 4'd1;
    end
    if (lsu_win) begin
      rd_addr_d = bus.lsu_rd_addr_i;
      rd_data_d = bus.lsu_rd_data_i;
      rd_wen_d  = bus.lsu_wen_i && (bus.lsu_rd_addr_i != 5'd0);
    end else if (alu_win) begin
      rd_addr_d = bus.alu_rd_addr_i;
      rd_data_d = bus.alu_rd_data_i;
      rd_wen_d  = bus.alu_wen_i && (bus.alu_rd_addr_i != 5'd0);
    end
  end

  // Scoreboard next-state: inc on issue, dec on the regfile write edge.
  always_comb begin
    cnt_d[0] = '0;
    for (int r = 1; r < 32; r++) begin
      logic inc, dec;
      cnt_d[r] = cnt_q[r];
      inc = iss_fire && (bus.iss_rd_addr_i == 5'(r));
      dec = rd_wen_q && (rd_addr_q == 5'(r));
      if (inc && !dec) begin
        cnt_d[r] = cnt_q[r] + PendOne;
      end else if (dec && !inc && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - PendOne;
      end
    end
  end

  // State registers; async reset discards pending writes and the output stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q  <= '0;
      rd_wen_q  <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      starve_q  <= starve_d;
      rd_wen_q  <= rd_wen_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ysyx_25040101_wbu.sv
// Self-checking bench for the writeback unit: a directed vector table plus
// hand-written multi-cycle sequences.
module tb_ysyx_25040101_wbu;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   dec_err;
  int   pend [32];

  ysyx_25040101_wbu_if bus ();

  ysyx_25040101_wbu #(
    .STARVE_MAX (4),
    .PEND_W     (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        alu_v;
    logic        alu_wen;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        lsu_v;
    logic        lsu_wen;
    logic [4:0]  lsu_addr;
    logic [31:0] lsu_data;
    logic        iss_v;
    logic [4:0]  iss_rd;
    logic        exp_alu_rdy;
    logic        exp_lsu_rdy;
    logic        exp_wen;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [8];

  // Independent pending-write count: a regfile write with nothing pending is illegal.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 32; r++) pend[r] = 0;
    end else begin
      int a;
      a = int'(bus.rd_addr_o);
      if (bus.rd_wen_o) begin
        if (pend[a] == 0) begin
          dec_err = dec_err + 1;
          $display("FAIL illegal_dec: write to x%0d with nothing pending, required a prior issue", a);
        end else begin
          pend[a] = pend[a] - 1;
        end
      end
      if (bus.iss_valid_i && bus.iss_ready_o && bus.iss_wen_i && bus.iss_rd_addr_i != 5'd0)
        pend[bus.iss_rd_addr_i] = pend[bus.iss_rd_addr_i] + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.iss_valid_i   = 1'b0;
    bus.iss_wen_i     = 1'b1;
    bus.iss_rd_addr_i = 5'd0;
    bus.alu_valid_i   = 1'b0;
    bus.alu_wen_i     = 1'b0;
    bus.alu_rd_addr_i = 5'd0;
    bus.alu_rd_data_i = 32'd0;
    bus.lsu_valid_i   = 1'b0;
    bus.lsu_wen_i     = 1'b0;
    bus.lsu_rd_addr_i = 5'd0;
    bus.lsu_rd_data_i = 32'd0;
  endtask

  task automatic drive_alu(input logic v, input logic wen, input logic [4:0] a,
                           input logic [31:0] d);
    bus.alu_valid_i   = v;
    bus.alu_wen_i     = wen;
    bus.alu_rd_addr_i = a;
    bus.alu_rd_data_i = d;
  endtask

  task automatic drive_lsu(input logic v, input logic wen, input logic [4:0] a,
                           input logic [31:0] d);
    bus.lsu_valid_i   = v;
    bus.lsu_wen_i     = wen;
    bus.lsu_rd_addr_i = a;
    bus.lsu_rd_data_i = d;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    dec_err = 0;
    rst     = 1'b0;
    idle();
    bus.rs1_addr_i = 5'd0;
    bus.rs2_addr_i = 5'd0;

    vecs[0] = '{1'b1, 1'b1, 5'd5,  32'h1234, 1'b0, 1'b0, 5'd0, 32'h0,
                1'b1, 5'd5,  1'b1, 1'b0, 1'b1, 5'd5,  32'h1234};
    vecs[1] = '{1'b0, 1'b0, 5'd0,  32'h0,    1'b0, 1'b0, 5'd0, 32'h0,
                1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd5,  32'h1234};
    vecs[2] = '{1'b0, 1'b0, 5'd0,  32'h0,    1'b1, 1'b1, 5'd6, 32'hBEEF,
                1'b1, 5'd6,  1'b0, 1'b1, 1'b1, 5'd6,  32'hBEEF};
    vecs[3] = '{1'b1, 1'b1, 5'd7,  32'h11,   1'b1, 1'b1, 5'd8, 32'h22,
                1'b1, 5'd8,  1'b0, 1'b1, 1'b1, 5'd8,  32'h22};
    vecs[4] = '{1'b1, 1'b1, 5'd0,  32'h33,   1'b0, 1'b0, 5'd0, 32'h0,
                1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 5'd0,  32'h33};
    vecs[5] = '{1'b0, 1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 5'd9, 32'h44,
                1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 5'd9,  32'h44};
    vecs[6] = '{1'b1, 1'b0, 5'd10, 32'h55,   1'b0, 1'b0, 5'd0, 32'h0,
                1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 5'd10, 32'h55};
    vecs[7] = '{1'b1, 1'b1, 5'd11, 32'h66,   1'b0, 1'b0, 5'd0, 32'h0,
                1'b1, 5'd11, 1'b1, 1'b0, 1'b1, 5'd11, 32'h66};

    // Reset hold with a valid ALU result that must be dropped.
    drive_alu(1'b1, 1'b1, 5'd5, 32'h1234);
    bus.iss_rd_addr_i = 5'd5;
    bus.rs1_addr_i    = 5'd5;
    tick();
    tick();
    chk("reset_rd_wen", 32'(bus.rd_wen_o), 32'd0);
    chk("reset_rd_addr", 32'(bus.rd_addr_o), 32'd0);
    chk("reset_rd_data", bus.rd_data_o, 32'd0);
    chk("reset_busy", 32'(bus.busy_o), 32'd0);
    chk("reset_iss_ready", 32'(bus.iss_ready_o), 32'd1);
    idle();
    bus.rs1_addr_i = 5'd0;
    rst = 1'b1;
    tick();
    chk("post_reset_rd_wen", 32'(bus.rd_wen_o), 32'd0);

    // Table of single-cycle transactions.
    for (int i = 0; i < 8; i++) begin
      drive_alu(vecs[i].alu_v, vecs[i].alu_wen, vecs[i].alu_addr, vecs[i].alu_data);
      drive_lsu(vecs[i].lsu_v, vecs[i].lsu_wen, vecs[i].lsu_addr, vecs[i].lsu_data);
      bus.iss_valid_i   = vecs[i].iss_v;
      bus.iss_rd_addr_i = vecs[i].iss_rd;
      #1;
      chk($sformatf("v%0d_alu_ready", i), 32'(bus.alu_ready_o), 32'(vecs[i].exp_alu_rdy));
      chk($sformatf("v%0d_lsu_ready", i), 32'(bus.lsu_ready_o), 32'(vecs[i].exp_lsu_rdy));
      chk($sformatf("v%0d_iss_ready", i), 32'(bus.iss_ready_o), 32'd1);
      tick();
      chk($sformatf("v%0d_rd_wen", i), 32'(bus.rd_wen_o), 32'(vecs[i].exp_wen));
      chk($sformatf("v%0d_rd_addr", i), 32'(bus.rd_addr_o), 32'(vecs[i].exp_addr));
      chk($sformatf("v%0d_rd_data", i), bus.rd_data_o, vecs[i].exp_data);
    end
    idle();
    tick();
    chk("drain_rd_wen", 32'(bus.rd_wen_o), 32'd0);

    // Scoreboard: issue x7, writeback x7, busy clears the cycle after the write.
    bus.iss_valid_i   = 1'b1;
    bus.iss_rd_addr_i = 5'd7;
    tick();
    idle();
    bus.rs1_addr_i = 5'd7;
    #1;
    chk("sb_busy_pending", 32'(bus.busy_o), 32'd1);
    drive_alu(1'b1, 1'b1, 5'd7, 32'hA5);
    #1;
    chk("sb_alu_ready", 32'(bus.alu_ready_o), 32'd1);
    chk("sb_busy_accept", 32'(bus.busy_o), 32'd1);
    tick();
    idle();
    #1;
    chk("sb_rd_wen", 32'(bus.rd_wen_o), 32'd1);
    chk("sb_rd_data", bus.rd_data_o, 32'hA5);
    chk("sb_busy_write", 32'(bus.busy_o), 32'd1);
    tick();
    chk("sb_busy_after", 32'(bus.busy_o), 32'd0);
    bus.rs1_addr_i    = 5'd0;
    bus.iss_valid_i   = 1'b1;
    bus.iss_rd_addr_i = 5'd0;
    tick();
    idle();
    #1;
    chk("sb_x0_busy", 32'(bus.busy_o), 32'd0);
    bus.rs1_addr_i = 5'd0;

    // Conflict with starvation: LSU x4, forced ALU, then LSU again.
    drive_alu(1'b1, 1'b0, 5'd1, 32'h100);
    drive_lsu(1'b1, 1'b0, 5'd2, 32'h200);
    for (int i = 0; i < 6; i++) begin
      logic lw;
      lw = (i != 4);
      #1;
      chk($sformatf("st%0d_lsu_ready", i), 32'(bus.lsu_ready_o), 32'(lw));
      chk($sformatf("st%0d_alu_ready", i), 32'(bus.alu_ready_o), 32'(!lw));
      tick();
      chk($sformatf("st%0d_rd_addr", i), 32'(bus.rd_addr_o), lw ? 32'd2 : 32'd1);
    end
    idle();
    tick();

    // Saturation of x9 at three in flight.
    bus.iss_valid_i   = 1'b1;
    bus.iss_rd_addr_i = 5'd9;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("sat%0d_iss_ready", i), 32'(bus.iss_ready_o), 32'd1);
      tick();
    end
    chk("sat_full_iss_ready", 32'(bus.iss_ready_o), 32'd0);
    drive_alu(1'b1, 1'b1, 5'd9, 32'h99);
    tick();
    drive_alu(1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("sat_wb_rd_wen", 32'(bus.rd_wen_o), 32'd1);
    chk("sat_wb_iss_ready", 32'(bus.iss_ready_o), 32'd0);
    tick();
    chk("sat_after_iss_ready", 32'(bus.iss_ready_o), 32'd1);
    idle();
    tick();

    // Simultaneous inc/dec on x3 keeps the count at one.
    bus.iss_valid_i   = 1'b1;
    bus.iss_rd_addr_i = 5'd3;
    tick();
    idle();
    drive_alu(1'b1, 1'b1, 5'd3, 32'h77);
    tick();
    idle();
    bus.iss_valid_i   = 1'b1;
    bus.iss_rd_addr_i = 5'd3;
    bus.rs2_addr_i    = 5'd3;
    #1;
    chk("sim_rd_wen", 32'(bus.rd_wen_o), 32'd1);
    chk("sim_rd_addr", 32'(bus.rd_addr_o), 32'd3);
    chk("sim_busy_during", 32'(bus.busy_o), 32'd1);
    tick();
    idle();
    drive_alu(1'b1, 1'b1, 5'd3, 32'h78);
    #1;
    chk("sim_busy_after", 32'(bus.busy_o), 32'd1);
    tick();
    idle();
    #1;
    chk("sim_2nd_rd_wen", 32'(bus.rd_wen_o), 32'd1);
    chk("sim_2nd_busy", 32'(bus.busy_o), 32'd1);
    tick();
    chk("sim_drained_busy", 32'(bus.busy_o), 32'd0);
    bus.rs2_addr_i = 5'd0;

    // Async reset with a write in flight.
    bus.iss_valid_i   = 1'b1;
    bus.iss_rd_addr_i = 5'd12;
    drive_lsu(1'b1, 1'b1, 5'd12, 32'hDEAD);
    tick();
    idle();
    chk("ar_rd_wen", 32'(bus.rd_wen_o), 32'd1);
    chk("ar_rd_data", bus.rd_data_o, 32'hDEAD);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_rd_wen_cleared", 32'(bus.rd_wen_o), 32'd0);
    chk("ar_rd_addr_cleared", 32'(bus.rd_addr_o), 32'd0);
    chk("ar_rd_data_cleared", bus.rd_data_o, 32'd0);
    bus.rs1_addr_i = 5'd12;
    bus.rs2_addr_i = 5'd9;
    #1;
    chk("ar_busy", 32'(bus.busy_o), 32'd0);
    tick();
    chk("ar_hold_rd_wen", 32'(bus.rd_wen_o), 32'd0);
    rst = 1'b1;
    tick();
    chk("ar_release_rd_wen", 32'(bus.rd_wen_o), 32'd0);
    chk("ar_release_busy", 32'(bus.busy_o), 32'd0);

    errors = errors + dec_err;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
